axis_beam_splitter: RTL and testbench

- Transmit-side counterpart of the four-channel receive combiner.
- Accepts one complex AXI-stream beam (paired real/imag streams of SDATA_WIDTH-bit beats, packed signed samples) and fans it out to channels 00, 01, 20 and 21.
- Each channel copy is scaled by its own signed per-channel weight, with rounding and saturation.
- Per-lane output registers decouple backpressure, so every lane receives each input beat exactly once.

---
 rtl/axis_beam_splitter.sv | 194 +++++++++++++++++++
 tb/tb_axis_beam_splitter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_beam_splitter.sv
// Fans one complex AXI-stream beam out to four weighted channel copies (8 lanes).
// Define AXIS_SPLIT_SAT_EN to saturate scaled samples instead of wrapping them.
module axis_beam_splitter #(
   parameter int SDATA_WIDTH   = 128,
   parameter int SSAMPLE_WIDTH = 16,
   parameter int WEIGHT_WIDTH  = 8
) (
   input  logic                     clock,
   input  logic                     resetn,

   input  logic                     s_axis_real_tvalid,
   output logic                     s_axis_real_tready,
   input  logic [SDATA_WIDTH-1:0]   s_axis_real_tdata,
   input  logic                     s_axis_real_tlast,
   input  logic                     s_axis_imag_tvalid,
   output logic                     s_axis_imag_tready,
   input  logic [SDATA_WIDTH-1:0]   s_axis_imag_tdata,
   input  logic                     s_axis_imag_tlast,

   input  logic [WEIGHT_WIDTH-1:0]  weight00,
   input  logic [WEIGHT_WIDTH-1:0]  weight01,
   input  logic [WEIGHT_WIDTH-1:0]  weight20,
   input  logic [WEIGHT_WIDTH-1:0]  weight21,

   output logic [SDATA_WIDTH-1:0]   m00_axis_real_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m00_axis_real_s2mm_tkeep,
   output logic                     m00_axis_real_s2mm_tlast,
   output logic                     m00_axis_real_s2mm_tvalid,
   input  logic                     m00_axis_real_s2mm_tready,
   output logic [SDATA_WIDTH-1:0]   m00_axis_imag_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m00_axis_imag_s2mm_tkeep,
   output logic                     m00_axis_imag_s2mm_tlast,
   output logic                     m00_axis_imag_s2mm_tvalid,
   input  logic                     m00_axis_imag_s2mm_tready,

   output logic [SDATA_WIDTH-1:0]   m01_axis_real_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m01_axis_real_s2mm_tkeep,
   output logic                     m01_axis_real_s2mm_tlast,
   output logic                     m01_axis_real_s2mm_tvalid,
   input  logic                     m01_axis_real_s2mm_tready,
   output logic [SDATA_WIDTH-1:0]   m01_axis_imag_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m01_axis_imag_s2mm_tkeep,
   output logic                     m01_axis_imag_s2mm_tlast,
   output logic                     m01_axis_imag_s2mm_tvalid,
   input  logic                     m01_axis_imag_s2mm_tready,

   output logic [SDATA_WIDTH-1:0]   m20_axis_real_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m20_axis_real_s2mm_tkeep,
   output logic                     m20_axis_real_s2mm_tlast,
   output logic                     m20_axis_real_s2mm_tvalid,
   input  logic                     m20_axis_real_s2mm_tready,
   output logic [SDATA_WIDTH-1:0]   m20_axis_imag_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m20_axis_imag_s2mm_tkeep,
   output logic                     m20_axis_imag_s2mm_tlast,
   output logic                     m20_axis_imag_s2mm_tvalid,
   input  logic                     m20_axis_imag_s2mm_tready,

   output logic [SDATA_WIDTH-1:0]   m21_axis_real_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m21_axis_real_s2mm_tkeep,
   output logic                     m21_axis_real_s2mm_tlast,
   output logic                     m21_axis_real_s2mm_tvalid,
   input  logic                     m21_axis_real_s2mm_tready,
   output logic [SDATA_WIDTH-1:0]   m21_axis_imag_s2mm_tdata,
   output logic [SDATA_WIDTH/8-1:0] m21_axis_imag_s2mm_tkeep,
   output logic                     m21_axis_imag_s2mm_tlast,
   output logic                     m21_axis_imag_s2mm_tvalid,
   input  logic                     m21_axis_imag_s2mm_tready
);

   localparam int SAMPLES = SDATA_WIDTH / SSAMPLE_WIDTH;
   localparam int KEEP_W  = SDATA_WIDTH / 8;
   localparam int LANES   = 8;
   localparam int PW      = SSAMPLE_WIDTH + WEIGHT_WIDTH;
   localparam logic signed [PW-1:0] RND = PW'(1) << (WEIGHT_WIDTH - 2);
   localparam logic signed [SSAMPLE_WIDTH:0] RMAX = (SSAMPLE_WIDTH+1)'((1 << (SSAMPLE_WIDTH - 1)) - 1);
   localparam logic signed [SSAMPLE_WIDTH:0] RMIN = -RMAX - 1;

   // Lane k = 2*channel + (0 real, 1 imag); channel order 00, 01, 20, 21.
   logic [SDATA_WIDTH-1:0]  lane_data [LANES];
   logic [SDATA_WIDTH-1:0]  next_data [LANES];
   logic [LANES-1:0]        lane_last, next_last, lane_v, lane_rdy;
   logic [WEIGHT_WIDTH-1:0] wt [4];
   logic                    s_ready, accept;

   function automatic logic [SSAMPLE_WIDTH-1:0] scale_sample(
      input logic signed [SSAMPLE_WIDTH-1:0] s,
      input logic signed [WEIGHT_WIDTH-1:0]  w
   );
      logic signed [PW-1:0]            p;
      logic signed [PW-1:0]            q;
      logic signed [SSAMPLE_WIDTH:0]   r;
      logic        [SSAMPLE_WIDTH-1:0] out;
      p = PW'(s) * PW'(w);
      q = p + RND;
      r = (SSAMPLE_WIDTH+1)'(q >>> (WEIGHT_WIDTH - 1));
`ifdef AXIS_SPLIT_SAT_EN
      out = SSAMPLE_WIDTH'((r > RMAX) ? RMAX : ((r < RMIN) ? RMIN : r));
`else
      out = SSAMPLE_WIDTH'(r);
`endif
      return out;
   endfunction

   function automatic logic [SDATA_WIDTH-1:0] scale_beat(
      input logic [SDATA_WIDTH-1:0]  d,
      input logic [WEIGHT_WIDTH-1:0] w
   );
      logic [SDATA_WIDTH-1:0] b;
      b = '0;
      for (int unsigned i = 0; i < SAMPLES; i++)
         b[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] = scale_sample(d[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH], w);
      return b;
   endfunction

   assign wt[0] = weight00;
   assign wt[1] = weight01;
   assign wt[2] = weight20;
   assign wt[3] = weight21;

   assign lane_rdy = {m21_axis_imag_s2mm_tready, m21_axis_real_s2mm_tready,
                      m20_axis_imag_s2mm_tready, m20_axis_real_s2mm_tready,
                      m01_axis_imag_s2mm_tready, m01_axis_real_s2mm_tready,
                      m00_axis_imag_s2mm_tready, m00_axis_real_s2mm_tready};

   always_comb begin
      for (int unsigned c = 0; c < 4; c++) begin
         next_data[2*c]   = scale_beat(s_axis_real_tdata, wt[c]);
         next_data[2*c+1] = scale_beat(s_axis_imag_tdata, wt[c]);
         next_last[2*c]   = s_axis_real_tlast;
         next_last[2*c+1] = s_axis_imag_tlast;
      end
   end

   // Every lane must be able to take a beat on this edge, so one stalled lane stops the input.
   assign s_ready            = &(~lane_v | lane_rdy);
   assign accept             = s_axis_real_tvalid & s_axis_imag_tvalid & s_ready;
   assign s_axis_real_tready = s_ready;
   assign s_axis_imag_tready = s_ready;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         lane_v    <= '0;
         lane_last <= '0;
         for (int unsigned k = 0; k < LANES; k++) lane_data[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < LANES; k++) begin
            if (accept) begin
               lane_data[k] <= next_data[k];
               lane_last[k] <= next_last[k];
               lane_v[k]    <= 1'b1;
            end else if (lane_rdy[k]) begin
               lane_v[k]    <= 1'b0;
            end
         end
      end
   end

   assign m00_axis_real_s2mm_tdata  = lane_data[0];
   assign m00_axis_real_s2mm_tkeep  = {KEEP_W{lane_v[0]}};
   assign m00_axis_real_s2mm_tlast  = lane_last[0];
   assign m00_axis_real_s2mm_tvalid = lane_v[0];
   assign m00_axis_imag_s2mm_tdata  = lane_data[1];
   assign m00_axis_imag_s2mm_tkeep  = {KEEP_W{lane_v[1]}};
   assign m00_axis_imag_s2mm_tlast  = lane_last[1];
   assign m00_axis_imag_s2mm_tvalid = lane_v[1];

   assign m01_axis_real_s2mm_tdata  = lane_data[2];
   assign m01_axis_real_s2mm_tkeep  = {KEEP_W{lane_v[2]}};
   assign m01_axis_real_s2mm_tlast  = lane_last[2];
   assign m01_axis_real_s2mm_tvalid = lane_v[2];
   assign m01_axis_imag_s2mm_tdata  = lane_data[3];
   assign m01_axis_imag_s2mm_tkeep  = {KEEP_W{lane_v[3]}};
   assign m01_axis_imag_s2mm_tlast  = lane_last[3];
   assign m01_axis_imag_s2mm_tvalid = lane_v[3];

   assign m20_axis_real_s2mm_tdata  = lane_data[4];
   assign m20_axis_real_s2mm_tkeep  = {KEEP_W{lane_v[4]}};
   assign m20_axis_real_s2mm_tlast  = lane_last[4];
   assign m20_axis_real_s2mm_tvalid = lane_v[4];
   assign m20_axis_imag_s2mm_tdata  = lane_data[5];
   assign m20_axis_imag_s2mm_tkeep  = {KEEP_W{lane_v[5]}};
   assign m20_axis_imag_s2mm_tlast  = lane_last[5];
   assign m20_axis_imag_s2mm_tvalid = lane_v[5];

   assign m21_axis_real_s2mm_tdata  = lane_data[6];
   assign m21_axis_real_s2mm_tkeep  = {KEEP_W{lane_v[6]}};
   assign m21_axis_real_s2mm_tlast  = lane_last[6];
   assign m21_axis_real_s2mm_tvalid = lane_v[6];
   assign m21_axis_imag_s2mm_tdata  = lane_data[7];
   assign m21_axis_imag_s2mm_tkeep  = {KEEP_W{lane_v[7]}};
   assign m21_axis_imag_s2mm_tlast  = lane_last[7];
   assign m21_axis_imag_s2mm_tvalid = lane_v[7];

endmodule

// File: tb/tb_axis_beam_splitter.sv
// Self-checking bench for axis_beam_splitter: directed cases plus a randomized
// stream scored against a 1-deep-buffer-per-lane model with integer arithmetic.
module tb_axis_beam_splitter;

   logic           clock = 1'b0;
   logic           resetn;
   logic           rv, iv, rl, il;
   logic [127:0]   rd, id;
   wire            rrdy, irdy;
   logic [3:0][7:0] w;
   logic [7:0]     m_rdy;
   wire  [127:0]   m_data [8];
   wire  [15:0]    m_keep [8];
   wire  [7:0]     m_last, m_valid;

   int checks = 0;
   int errors = 0;
   logic [128:0] exp_q [8][$];

   always #5 clock = ~clock;

   axis_beam_splitter #(.SDATA_WIDTH(128), .SSAMPLE_WIDTH(16), .WEIGHT_WIDTH(8)) dut (
      .clock(clock), .resetn(resetn),
      .s_axis_real_tvalid(rv), .s_axis_real_tready(rrdy), .s_axis_real_tdata(rd), .s_axis_real_tlast(rl),
      .s_axis_imag_tvalid(iv), .s_axis_imag_tready(irdy), .s_axis_imag_tdata(id), .s_axis_imag_tlast(il),
      .weight00(w[0]), .weight01(w[1]), .weight20(w[2]), .weight21(w[3]),
      .m00_axis_real_s2mm_tdata(m_data[0]), .m00_axis_real_s2mm_tkeep(m_keep[0]), .m00_axis_real_s2mm_tlast(m_last[0]),
      .m00_axis_real_s2mm_tvalid(m_valid[0]), .m00_axis_real_s2mm_tready(m_rdy[0]),
      .m00_axis_imag_s2mm_tdata(m_data[1]), .m00_axis_imag_s2mm_tkeep(m_keep[1]), .m00_axis_imag_s2mm_tlast(m_last[1]),
      .m00_axis_imag_s2mm_tvalid(m_valid[1]), .m00_axis_imag_s2mm_tready(m_rdy[1]),
      .m01_axis_real_s2mm_tdata(m_data[2]), .m01_axis_real_s2mm_tkeep(m_keep[2]), .m01_axis_real_s2mm_tlast(m_last[2]),
      .m01_axis_real_s2mm_tvalid(m_valid[2]), .m01_axis_real_s2mm_tready(m_rdy[2]),
      .m01_axis_imag_s2mm_tdata(m_data[3]), .m01_axis_imag_s2mm_tkeep(m_keep[3]), .m01_axis_imag_s2mm_tlast(m_last[3]),
      .m01_axis_imag_s2mm_tvalid(m_valid[3]), .m01_axis_imag_s2mm_tready(m_rdy[3]),
      .m20_axis_real_s2mm_tdata(m_data[4]), .m20_axis_real_s2mm_tkeep(m_keep[4]), .m20_axis_real_s2mm_tlast(m_last[4]),
      .m20_axis_real_s2mm_tvalid(m_valid[4]), .m20_axis_real_s2mm_tready(m_rdy[4]),
      .m20_axis_imag_s2mm_tdata(m_data[5]), .m20_axis_imag_s2mm_tkeep(m_keep[5]), .m20_axis_imag_s2mm_tlast(m_last[5]),
      .m20_axis_imag_s2mm_tvalid(m_valid[5]), .m20_axis_imag_s2mm_tready(m_rdy[5]),
      .m21_axis_real_s2mm_tdata(m_data[6]), .m21_axis_real_s2mm_tkeep(m_keep[6]), .m21_axis_real_s2mm_tlast(m_last[6]),
      .m21_axis_real_s2mm_tvalid(m_valid[6]), .m21_axis_real_s2mm_tready(m_rdy[6]),
      .m21_axis_imag_s2mm_tdata(m_data[7]), .m21_axis_imag_s2mm_tkeep(m_keep[7]), .m21_axis_imag_s2mm_tlast(m_last[7]),
      .m21_axis_imag_s2mm_tvalid(m_valid[7]), .m21_axis_imag_s2mm_tready(m_rdy[7])
   );

   // Reference: exact integer product, round half up by floor((p+64)/128), then clamp or wrap.
   function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic [7:0] wt);
      logic [127:0] b;
      int p, r;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         p = int'($signed(d[i*16 +: 16])) * int'($signed(wt));
         r = (p + 64) >>> 7;
`ifdef AXIS_SPLIT_SAT_EN
         if (r > 32767) r = 32767;
         if (r < -32768) r = -32768;
`endif
         b[i*16 +: 16] = r[15:0];
      end
      return b;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic bit model_empty();
      for (int k = 0; k < 8; k++) if (exp_q[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic test_reset();
      resetn = 1'b0; rv = 1'b0; iv = 1'b0; rl = 1'b0; il = 1'b0;
      rd = '0; id = '0; w = '0; m_rdy = '0;
      repeat (2) @(negedge clock);
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (m_valid[k] !== 1'b0 || m_last[k] !== 1'b0 || m_keep[k] !== 16'h0 || m_data[k] !== 128'h0) begin
            errors++;
            $display("FAIL reset lane %0d: valid=%b last=%b keep=%h data=%h, want all zero", k, m_valid[k], m_last[k], m_keep[k], m_data[k]);
         end
      end
      checks++;
      if (rrdy !== 1'b1 || irdy !== 1'b1) begin
         errors++;
         $display("FAIL reset s_tready: real=%b imag=%b, want 1", rrdy, irdy);
      end
      resetn = 1'b1;
      m_rdy = '1;
      @(negedge clock);
   endtask

   task automatic test_basic_scaling();
      logic [15:0] ec [4];
      ec[0] = 16'h0800; ec[1] = 16'h0400; ec[2] = 16'hF800; ec[3] = 16'h0000;
      w[0] = 8'h40; w[1] = 8'h20; w[2] = 8'hC0; w[3] = 8'h00;
      rd = {8{16'h1000}}; id = {8{16'h1000}}; rl = 1'b1; il = 1'b0;
      rv = 1'b1; iv = 1'b1; m_rdy = '1;
      @(negedge clock);
      rv = 1'b0; iv = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (m_valid[k] !== 1'b1 || m_data[k] !== {8{ec[k/2]}} || m_last[k] !== ((k % 2) == 0) || m_keep[k] !== 16'hFFFF) begin
            errors++;
            $display("FAIL basic lane %0d: valid=%b last=%b keep=%h data=%h, want 1 %b ffff %h",
                     k, m_valid[k], m_last[k], m_keep[k], m_data[k], ((k % 2) == 0), {8{ec[k/2]}});
         end
      end
      @(negedge clock);
      #1;
      checks++;
      if (m_valid !== 8'h00) begin
         errors++;
         $display("FAIL basic drain: tvalid=%b, want 00000000", m_valid);
      end
   endtask

   task automatic test_rounding();
      w = {4{8'h40}};
      rd = {4{16'hFFFF, 16'h0001}}; id = rd; rl = 1'b0; il = 1'b0;
      rv = 1'b1; iv = 1'b1;
      @(negedge clock);
      rv = 1'b0; iv = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (m_valid[k] !== 1'b1 || m_data[k] !== {4{16'h0000, 16'h0001}}) begin
            errors++;
            $display("FAIL rounding lane %0d: valid=%b data=%h, want 1 %h", k, m_valid[k], m_data[k], {4{16'h0000, 16'h0001}});
         end
      end
      @(negedge clock);
   endtask

   task automatic test_saturation();
      logic [15:0] es;
`ifdef AXIS_SPLIT_SAT_EN
      es = 16'h7FFF;
`else
      es = 16'h8000;
`endif
      w = {4{8'h80}};
      rd = {8{16'h8000}}; id = rd;
      rv = 1'b1; iv = 1'b1;
      @(negedge clock);
      rv = 1'b0; iv = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (m_valid[k] !== 1'b1 || m_data[k] !== {8{es}}) begin
            errors++;
            $display("FAIL saturation lane %0d: valid=%b data=%h, want 1 %h", k, m_valid[k], m_data[k], {8{es}});
         end
      end
      @(negedge clock);
   endtask

   task automatic test_partial_backpressure();
      logic [127:0] bre [4], bim [4];
      int sent = 0, c = 0;
      int cnt [8];
      bit exp_ready;
      for (int j = 0; j < 4; j++) begin bre[j] = rand128(); bim[j] = rand128(); end
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      w = {$urandom};
      while (!(sent == 4 && model_empty()) && c < 40) begin
         m_rdy = '1;
         if (c >= 1 && c <= 3) m_rdy[2] = 1'b0;
         rv = (sent < 4); iv = (sent < 4);
         rd = (sent < 4) ? bre[sent] : '0;
         id = (sent < 4) ? bim[sent] : '0;
         rl = (sent == 3); il = (sent == 3);
         #1;
         exp_ready = 1'b1;
         for (int k = 0; k < 8; k++) if (exp_q[k].size() != 0 && !m_rdy[k]) exp_ready = 1'b0;
         checks++;
         if (rrdy !== exp_ready || irdy !== exp_ready) begin
            errors++;
            $display("FAIL backpressure s_tready cycle %0d: real=%b imag=%b, want %b", c, rrdy, irdy, exp_ready);
         end
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (m_valid[k] !== (exp_q[k].size() != 0)) begin
               errors++;
               $display("FAIL backpressure tvalid lane %0d cycle %0d: got %b want %b", k, c, m_valid[k], exp_q[k].size() != 0);
            end else if (exp_q[k].size() != 0) begin
               checks++;
               if ({m_last[k], m_data[k]} !== exp_q[k][0]) begin
                  errors++;
                  $display("FAIL backpressure beat lane %0d cycle %0d: got %h want %h", k, c, {m_last[k], m_data[k]}, exp_q[k][0]);
               end
               if (m_rdy[k]) begin void'(exp_q[k].pop_front()); cnt[k]++; end
            end
         end
         if (rv && iv && exp_ready) begin
            for (int k = 0; k < 8; k++)
               exp_q[k].push_back((k % 2) ? {il, ref_beat(id, w[k/2])} : {rl, ref_beat(rd, w[k/2])});
            sent++;
         end
         @(negedge clock);
         c++;
      end
      rv = 1'b0; iv = 1'b0; m_rdy = '1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (cnt[k] !== 4) begin
            errors++;
            $display("FAIL backpressure count lane %0d: got %0d beats want 4", k, cnt[k]);
         end
         exp_q[k].delete();
      end
   endtask

   task automatic test_unpaired_valid();
      logic [127:0] er, ei;
      w = {$urandom};
      rd = rand128(); id = rand128(); rl = 1'b0; il = 1'b1;
      rv = 1'b1; iv = 1'b0; m_rdy = '1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         #1;
         checks++;
         if (m_valid !== 8'h00 || rrdy !== 1'b1) begin
            errors++;
            $display("FAIL unpaired cycle %0d: tvalid=%b s_tready=%b, want 00000000 1", i, m_valid, rrdy);
         end
      end
      iv = 1'b1;
      @(negedge clock);
      rv = 1'b0; iv = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         er = ref_beat(rd, w[k/2]); ei = ref_beat(id, w[k/2]);
         checks++;
         if (m_valid[k] !== 1'b1 || m_data[k] !== ((k % 2) ? ei : er) || m_last[k] !== ((k % 2) == 1)) begin
            errors++;
            $display("FAIL unpaired accept lane %0d: valid=%b last=%b data=%h, want 1 %b %h",
                     k, m_valid[k], m_last[k], m_data[k], ((k % 2) == 1), (k % 2) ? ei : er);
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid_stall();
      rd = rand128(); id = rand128(); rl = 1'b1; il = 1'b1; w = {$urandom};
      rv = 1'b1; iv = 1'b1; m_rdy = '0;
      @(negedge clock);
      rv = 1'b0; iv = 1'b0;
      #1;
      checks++;
      if (m_valid !== 8'hFF || rrdy !== 1'b0) begin
         errors++;
         $display("FAIL stall before reset: tvalid=%b s_tready=%b, want 11111111 0", m_valid, rrdy);
      end
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (m_valid[k] !== 1'b0 || m_last[k] !== 1'b0 || m_keep[k] !== 16'h0 || m_data[k] !== 128'h0) begin
            errors++;
            $display("FAIL mid-stall reset lane %0d: valid=%b last=%b keep=%h data=%h, want all zero", k, m_valid[k], m_last[k], m_keep[k], m_data[k]);
         end
      end
      checks++;
      if (rrdy !== 1'b1 || irdy !== 1'b1) begin
         errors++;
         $display("FAIL mid-stall reset s_tready: real=%b imag=%b, want 1", rrdy, irdy);
      end
      m_rdy = '1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         #1;
         checks++;
         if (m_valid !== 8'h00) begin
            errors++;
            $display("FAIL stale beat after reset cycle %0d: tvalid=%b, want 00000000", i, m_valid);
         end
      end
   endtask

   task automatic test_random_stream();
      int sent = 0, c = 0;
      bit exp_ready;
      while (!(sent >= 60 && model_empty()) && c < 2000) begin
         for (int k = 0; k < 8; k++) m_rdy[k] = ($urandom_range(0, 3) != 0);
         w = {$urandom};
         rd = rand128(); id = rand128(); rl = $urandom_range(0, 1); il = $urandom_range(0, 1);
         rv = (sent < 60) && ($urandom_range(0, 3) != 0);
         iv = ($urandom_range(0, 4) != 0) ? rv : (sent < 60) && ($urandom_range(0, 1) != 0);
         #1;
         exp_ready = 1'b1;
         for (int k = 0; k < 8; k++) if (exp_q[k].size() != 0 && !m_rdy[k]) exp_ready = 1'b0;
         checks++;
         if (rrdy !== exp_ready || irdy !== exp_ready) begin
            errors++;
            $display("FAIL random s_tready cycle %0d: real=%b imag=%b, want %b", c, rrdy, irdy, exp_ready);
         end
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (m_valid[k] !== (exp_q[k].size() != 0)) begin
               errors++;
               $display("FAIL random tvalid lane %0d cycle %0d: got %b want %b", k, c, m_valid[k], exp_q[k].size() != 0);
            end else if (exp_q[k].size() != 0) begin
               checks++;
               if ({m_last[k], m_data[k]} !== exp_q[k][0] || m_keep[k] !== 16'hFFFF) begin
                  errors++;
                  $display("FAIL random beat lane %0d cycle %0d: got %h keep %h want %h keep ffff", k, c, {m_last[k], m_data[k]}, m_keep[k], exp_q[k][0]);
               end
               if (m_rdy[k]) void'(exp_q[k].pop_front());
            end
         end
         if (rv && iv && exp_ready) begin
            for (int k = 0; k < 8; k++)
               exp_q[k].push_back((k % 2) ? {il, ref_beat(id, w[k/2])} : {rl, ref_beat(rd, w[k/2])});
            sent++;
         end
         @(negedge clock);
         c++;
      end
      checks++;
      if (!(sent >= 60 && model_empty())) begin
         errors++;
         $display("FAIL random timeout: sent %0d beats, want 60 delivered within 2000 cycles", sent);
      end
      rv = 1'b0; iv = 1'b0; m_rdy = '1;
      for (int k = 0; k < 8; k++) exp_q[k].delete();
   endtask

   initial begin
      test_reset();
      test_basic_scaling();
      test_rounding();
      test_saturation();
      test_partial_backpressure();
      test_unpaired_valid();
      test_random_stream();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
